// File: rtl/regbank_pkg.sv
// Shared types and default sizing for the register bank.
// Pure declarations: no logic, no latency, no flow control.
package regbank_pkg;

    localparam int REGBANK_DEFAULT_WIDTH = 16;
    localparam int REGBANK_DEFAULT_DEPTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } regbank_state_t;

endpackage

// File: rtl/register_bank_cell.sv
// One storage word: load enable with a synchronous clear that wins over load.
// One-cycle load latency; no backpressure, the caller gates load/clr.
module register_bank_cell #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (clr) begin
            data_d = '0;
        end else if (load) begin
            data_d = d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/register_bank.sv
// DEPTH x WIDTH register file: 1 write port, 2 combinational read ports, sequenced bulk clear.
// Writes land next edge; clear takes DEPTH cycles with busy high, writes while busy are dropped (sticky flag).
// REGISTER_BANK_BYPASS_EN enables same-cycle write/clear forwarding onto the read ports.
module register_bank
    import regbank_pkg::*;
#(
    parameter  int WIDTH  = REGBANK_DEFAULT_WIDTH,
    parameter  int DEPTH  = REGBANK_DEFAULT_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [WIDTH-1:0]  rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [WIDTH-1:0]  rd_data_b,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_done,
    output logic              wr_dropped
);

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    regbank_state_t    state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              clr_done_q, clr_done_d;
    logic              wr_dropped_q, wr_dropped_d;

    logic              wr_accept;
    logic [DEPTH-1:0]  cell_load;
    logic [DEPTH-1:0]  cell_clr;
    logic [WIDTH-1:0]  cell_q [DEPTH];

    assign busy      = (state_q == CLEAR);
    assign wr_accept = wr_en && !busy;

    // clr_done is registered: it is set on the edge that moves ptr onto the last word.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        clr_done_d   = 1'b0;
        wr_dropped_d = wr_dropped_q;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                end
            end
            CLEAR: begin
                if (wr_en) begin
                    wr_dropped_d = 1'b1;
                end
                if (ptr_q == LAST_PTR) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d      = ptr_q + 1'b1;
                    clr_done_d = (ptr_d == LAST_PTR);
                end
            end
            default: begin
                state_d = IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            clr_done_q   <= 1'b0;
            wr_dropped_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            clr_done_q   <= clr_done_d;
            wr_dropped_q <= wr_dropped_d;
        end
    end

    assign clr_done   = clr_done_q;
    assign wr_dropped = wr_dropped_q;

    always_comb begin
        cell_load = '0;
        cell_clr  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cell_load[i] = wr_accept && (wr_addr == ADDR_W'(i));
            cell_clr[i]  = busy && (ptr_q == ADDR_W'(i));
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_cell
        register_bank_cell #(
            .WIDTH (WIDTH)
        ) u_cell (
            .clock   (clock),
            .reset_n (reset_n),
            .load    (cell_load[g]),
            .clr     (cell_clr[g]),
            .d       (wr_data),
            .q       (cell_q[g])
        );
    end

`ifdef REGISTER_BANK_BYPASS_EN
    always_comb begin
        rd_data_a = cell_q[rd_addr_a];
        if (wr_accept && (rd_addr_a == wr_addr)) begin
            rd_data_a = wr_data;
        end else if (busy && (rd_addr_a == ptr_q)) begin
            rd_data_a = '0;
        end
    end

    always_comb begin
        rd_data_b = cell_q[rd_addr_b];
        if (wr_accept && (rd_addr_b == wr_addr)) begin
            rd_data_b = wr_data;
        end else if (busy && (rd_addr_b == ptr_q)) begin
            rd_data_b = '0;
        end
    end
`else
    assign rd_data_a = cell_q[rd_addr_a];
    assign rd_data_b = cell_q[rd_addr_b];
`endif

endmodule

// File: tb/tb_register_bank.sv
// Randomised and directed bench for register_bank against an array-based model.
module tb_register_bank;

    localparam int W = 16;
    localparam int D = 8;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          wr_en;
    logic [2:0]    wr_addr;
    logic [W-1:0]  wr_data;
    logic [2:0]    rd_addr_a;
    logic [W-1:0]  rd_data_a;
    logic [2:0]    rd_addr_b;
    logic [W-1:0]  rd_data_b;
    logic          clr_req;
    logic          busy;
    logic          clr_done;
    logic          wr_dropped;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] mdl [D];
    int           clr_left;
    bit           dropped_m;

    register_bank #(.WIDTH(W), .DEPTH(D)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_addr_a  (rd_addr_a),
        .rd_data_a  (rd_data_a),
        .rd_addr_b  (rd_addr_b),
        .rd_data_b  (rd_data_b),
        .clr_req    (clr_req),
        .busy       (busy),
        .clr_done   (clr_done),
        .wr_dropped (wr_dropped)
    );

    always #5 clock = ~clock;

    task automatic model_reset();
        for (int i = 0; i < D; i++) mdl[i] = '0;
        clr_left  = 0;
        dropped_m = 1'b0;
    endtask

    // Apply the current inputs to the model, then advance to just after the edge.
    task automatic model_edge();
        if (clr_left > 0) begin
            if (wr_en) dropped_m = 1'b1;
            mdl[D - clr_left] = '0;
            clr_left--;
        end else begin
            if (wr_en) mdl[wr_addr] = wr_data;
            if (clr_req) clr_left = D;
        end
        @(posedge clock);
        #1;
    endtask

    function automatic logic [W-1:0] exp_rd(input logic [2:0] a);
`ifdef REGISTER_BANK_BYPASS_EN
        if (clr_left == 0 && wr_en && a == wr_addr) return wr_data;
        if (clr_left > 0 && int'(a) == D - clr_left) return '0;
`endif
        return mdl[a];
    endfunction

    task automatic idle_inputs();
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        rd_addr_a = '0;
        rd_addr_b = '0;
        clr_req   = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 1'b0;
        model_reset();
        #20;
        for (int i = 0; i < D; i++) begin
            rd_addr_a = 3'(i);
            rd_addr_b = 3'(D - 1 - i);
            #1;
            checks++;
            if (rd_data_a !== 16'h0000) begin
                errors++;
                $display("FAIL reset_rd_a[%0d]: got %h expected 0000", i, rd_data_a);
            end
            checks++;
            if (rd_data_b !== 16'h0000) begin
                errors++;
                $display("FAIL reset_rd_b[%0d]: got %h expected 0000", D - 1 - i, rd_data_b);
            end
        end
        checks++;
        if ({busy, clr_done, wr_dropped} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got busy/done/dropped=%b expected 000", {busy, clr_done, wr_dropped});
        end
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic test_write_read();
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'hBEEF;
        model_edge();
        wr_en = 1'b0; rd_addr_a = 3'd3; rd_addr_b = 3'd2;
        @(negedge clock);
        checks++;
        if (rd_data_a !== 16'hBEEF) begin
            errors++;
            $display("FAIL write_read_a: got %h expected beef", rd_data_a);
        end
        checks++;
        if (rd_data_b !== 16'h0000) begin
            errors++;
            $display("FAIL write_read_b: got %h expected 0000", rd_data_b);
        end
        model_edge();
    endtask

    task automatic test_same_cycle();
        logic [W-1:0] want;
`ifdef REGISTER_BANK_BYPASS_EN
        want = 16'h1234;
`else
        want = 16'h0000;
`endif
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'h1234; rd_addr_a = 3'd5;
        @(negedge clock);
        checks++;
        if (rd_data_a !== want) begin
            errors++;
            $display("FAIL same_cycle_rd: got %h expected %h", rd_data_a, want);
        end
        model_edge();
        wr_en = 1'b0;
        @(negedge clock);
        checks++;
        if (rd_data_a !== 16'h1234) begin
            errors++;
            $display("FAIL after_write_rd: got %h expected 1234", rd_data_a);
        end
        model_edge();
    endtask

    task automatic test_bulk_clear();
        for (int i = 0; i < D; i++) begin
            wr_en = 1'b1; wr_addr = 3'(i); wr_data = 16'(16'h1111 * i);
            model_edge();
        end
        wr_en = 1'b0; rd_addr_a = 3'd7; clr_req = 1'b1;
        @(negedge clock);
        checks++;
        if (rd_data_a !== 16'h7777 || busy !== 1'b0) begin
            errors++;
            $display("FAIL fill_check: got rd=%h busy=%b expected 7777 0", rd_data_a, busy);
        end
        model_edge();
        clr_req = 1'b0;
        for (int i = 0; i < D; i++) begin
            wr_en   = (i == 2);
            wr_addr = 3'd1;
            wr_data = 16'hAAAA;
            clr_req = (i == 4);
            @(negedge clock);
            checks++;
            if (busy !== 1'b1 || clr_done !== (i == D - 1)) begin
                errors++;
                $display("FAIL clear_cycle[%0d]: got busy=%b done=%b expected 1 %b", i, busy, clr_done, i == D - 1);
            end
            model_edge();
        end
        idle_inputs();
        @(negedge clock);
        checks++;
        if ({busy, clr_done, wr_dropped} !== 3'b001) begin
            errors++;
            $display("FAIL clear_end_flags: got busy/done/dropped=%b expected 001", {busy, clr_done, wr_dropped});
        end
        for (int i = 0; i < D; i++) begin
            rd_addr_a = 3'(i);
            rd_addr_b = 3'(i ^ 1);
            #1;
            checks++;
            if (rd_data_a !== 16'h0000 || rd_data_b !== 16'h0000) begin
                errors++;
                $display("FAIL cleared_reg[%0d]: got a=%h b=%h expected 0000", i, rd_data_a, rd_data_b);
            end
        end
        model_edge();
    endtask

    task automatic test_reset_mid_clear();
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_addr = 3'(i + 4); wr_data = 16'(16'hC000 + i);
            model_edge();
        end
        wr_en = 1'b0; clr_req = 1'b1;
        model_edge();
        clr_req = 1'b0;
        model_edge();
        model_edge();
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, clr_done, wr_dropped} !== 3'b000) begin
            errors++;
            $display("FAIL abort_flags: got busy/done/dropped=%b expected 000", {busy, clr_done, wr_dropped});
        end
        for (int i = 0; i < D; i++) begin
            rd_addr_a = 3'(i);
            #1;
            checks++;
            if (rd_data_a !== 16'h0000) begin
                errors++;
                $display("FAIL abort_reg[%0d]: got %h expected 0000", i, rd_data_a);
            end
        end
        model_reset();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        wr_en = 1'b1; wr_addr = 3'd6; wr_data = 16'h5A5A;
        @(negedge clock);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: got busy=%b expected 0", busy);
        end
        model_edge();
        wr_en = 1'b0; rd_addr_b = 3'd6;
        @(negedge clock);
        checks++;
        if (rd_data_b !== 16'h5A5A) begin
            errors++;
            $display("FAIL abort_write: got %h expected 5a5a", rd_data_b);
        end
        model_edge();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            wr_en     = ($urandom_range(0, 1) == 1);
            wr_addr   = 3'($urandom_range(0, D - 1));
            wr_data   = 16'($urandom);
            rd_addr_a = 3'($urandom_range(0, D - 1));
            rd_addr_b = ($urandom_range(0, 3) == 0) ? wr_addr : 3'($urandom_range(0, D - 1));
            clr_req   = ($urandom_range(0, 24) == 0);
            @(negedge clock);
            checks++;
            if (rd_data_a !== exp_rd(rd_addr_a)) begin
                errors++;
                $display("FAIL rand_rd_a[%0d]: got %h expected %h", n, rd_data_a, exp_rd(rd_addr_a));
            end
            checks++;
            if (rd_data_b !== exp_rd(rd_addr_b)) begin
                errors++;
                $display("FAIL rand_rd_b[%0d]: got %h expected %h", n, rd_data_b, exp_rd(rd_addr_b));
            end
            checks++;
            if (busy !== (clr_left > 0) || clr_done !== (clr_left == 1)) begin
                errors++;
                $display("FAIL rand_fsm[%0d]: got busy=%b done=%b expected %b %b", n, busy, clr_done, clr_left > 0, clr_left == 1);
            end
            checks++;
            if (wr_dropped !== dropped_m) begin
                errors++;
                $display("FAIL rand_dropped[%0d]: got %b expected %b", n, wr_dropped, dropped_m);
            end
            model_edge();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_same_cycle();
        test_bulk_clear();
        test_reset_mid_clear();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
